uart_rx_ctrl: RTL

Receive-side controller for the UART SIPO deserialiser.
- Generates the 16x-oversampling baud_clk from the system clock and holds the SIPO in reset while receive is disabled.
- Captures each completed 11-bit frame, checks start, stop and parity bits, and pushes good frames into a small first-word-fall-through FIFO.
- The CPU/peripheral bus reads the FIFO through a valid/ready port.

---
 rtl/uart_rx_ctrl.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_ctrl.sv
// Receive-side controller for the UART SIPO: baud generation, frame checking and RX FIFO.
// Optional break detection is enabled by defining UART_RX_BREAK_DET_EN.
module uart_rx_ctrl #(
   parameter int unsigned DIV_W      = 16,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          rx_en,
   input  logic                          parity_odd,
   input  logic [DIV_W-1:0]              baud_div,
   input  logic                          err_clr,
   output logic                          baud_clk,
   output logic                          sipo_reset_n,
   input  logic                          sipo_active,
   input  logic                          sipo_recieved,
   input  logic [10:0]                   sipo_frame,
   output logic                          rd_valid,
   input  logic                          rd_ready,
   output logic [7:0]                    rd_data,
   output logic                          rd_perr,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          frame_err,
   output logic                          overrun,
   output logic                          break_det,
   output logic                          busy
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FifoFull = CNT_W'(FIFO_DEPTH);

   typedef enum logic [1:0] {StDisabled, StListen, StCheck} state_e;

   state_e state_q, state_d;

   // ---------------------------------------------------------------- baud generator
   logic [DIV_W-1:0] div_q, baud_cnt_q;
   logic             baud_clk_q;

   // The divisor is re-latched only at wrap so a new value never truncates a half-period.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div_q      <= '0;
         baud_cnt_q <= '0;
         baud_clk_q <= 1'b0;
      end else if (!rx_en) begin
         div_q      <= baud_div;
         baud_cnt_q <= '0;
         baud_clk_q <= 1'b0;
      end else if (baud_cnt_q == div_q) begin
         div_q      <= baud_div;
         baud_cnt_q <= '0;
         baud_clk_q <= ~baud_clk_q;
      end else begin
         baud_cnt_q <= baud_cnt_q + 1'b1;
      end
   end

   assign baud_clk = baud_clk_q;

   // ---------------------------------------------------------------- synchronisers
   logic [1:0] act_sync_q, rcv_sync_q;
   logic       rcv_prev_q;
   logic       rcv_rise;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         act_sync_q <= '0;
         rcv_sync_q <= '0;
         rcv_prev_q <= 1'b0;
      end else begin
         act_sync_q <= {act_sync_q[0], sipo_active};
         rcv_sync_q <= {rcv_sync_q[0], sipo_recieved};
         rcv_prev_q <= rcv_sync_q[1];
      end
   end

   assign rcv_rise = rcv_sync_q[1] & ~rcv_prev_q;

   // ---------------------------------------------------------------- FSM
   logic chk_en;
   logic frame_load;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StDisabled;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (!rx_en) begin
         state_d = StDisabled;
      end else begin
         unique case (state_q)
            StDisabled: state_d = StListen;
            StListen:   if (rcv_rise) state_d = StCheck;
            StCheck:    state_d = StListen;
            default:    state_d = StDisabled;
         endcase
      end
   end

   always_comb begin
      sipo_reset_n = (state_q != StDisabled);
      busy         = (state_q != StDisabled) & (act_sync_q[1] | (state_q == StCheck));
      // A frame still in CHECK when rx_en drops is discarded.
      chk_en       = (state_q == StCheck) & rx_en;
      frame_load   = (state_q == StListen) & rcv_rise & rx_en;
   end

   // ---------------------------------------------------------------- frame capture and check
   logic [10:0] frame_q;
   logic        ferr, perr, brk;
   logic        good, ferr_hit, ovr_hit;
   logic        push, pop, full;

   // The SIPO holds data_parll stable during HOLD, so no synchroniser is needed here.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         frame_q <= '0;
      end else if (frame_load) begin
         frame_q <= sipo_frame;
      end
   end

   always_comb begin
      ferr = frame_q[0] | ~frame_q[10];
      perr = (^frame_q[9:1]) ^ parity_odd;
`ifdef UART_RX_BREAK_DET_EN
      brk  = (frame_q == 11'h000);
`else
      brk  = 1'b0;
`endif
      full     = (fifo_count == FifoFull);
      pop      = rd_valid & rd_ready;
      good     = chk_en & ~ferr & ~brk;
      ferr_hit = chk_en & ferr & ~brk;
      push     = good & (~full | pop);
      ovr_hit  = good & full & ~pop;
   end

   // ---------------------------------------------------------------- sticky flags
   logic frame_err_q, overrun_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         frame_err_q <= ferr_hit | (frame_err_q & ~err_clr);
         overrun_q   <= ovr_hit | (overrun_q & ~err_clr);
      end
   end

   assign frame_err = frame_err_q;
   assign overrun   = overrun_q;

`ifdef UART_RX_BREAK_DET_EN
   logic brk_hit;
   logic break_q;

   assign brk_hit = chk_en & brk;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         break_q <= 1'b0;
      end else begin
         break_q <= brk_hit | (break_q & ~err_clr);
      end
   end

   assign break_det = break_q;
`else
   assign break_det = 1'b0;
`endif

   // ---------------------------------------------------------------- RX FIFO (FWFT)
   logic [8:0]       mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         if (push) begin
            mem_q[wr_ptr_q] <= {perr, frame_q[8:1]};
            wr_ptr_q        <= wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         count_q <= count_d;
      end
   end

   always_comb begin
      fifo_count = count_q;
      rd_valid   = (count_q != '0);
      rd_data    = rd_valid ? mem_q[rd_ptr_q][7:0] : 8'h00;
      rd_perr    = rd_valid ? mem_q[rd_ptr_q][8] : 1'b0;
   end

endmodule
